muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 33 +++
 rtl/muldiv_seq.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- handshake and data bundle between the EX stage and the
// sequential RV32M multiply/divide unit.
//   start   : EX stage presents an RV32M op (sampled only when the unit is idle)
//   funct3  : RV32M selector (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a    : rs1 value (multiplicand / dividend)
//   op_b    : rs2 value (multiplier / divisor)
//   flush   : pipeline flush, aborts any in-flight op
//   stall   : holds PC, IF/ID and ID/EX while high
//   busy    : unit is not idle
//   done    : one-cycle pulse, result valid
//   result  : RV32M result, held until the next completed op or reset
// master = pipeline side, slave = arithmetic unit side.
interface muldiv_seq_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative RV32M multiply/divide unit.
// Multiplication is radix-2 shift-add over a 64-bit product register and
// division is restoring shift-subtract with a 33-bit partial remainder; both
// run on magnitudes for 32 cycles, then one cycle of sign correction.
// Divide-by-zero and signed-overflow divisions skip the iterations and finish
// one cycle after acceptance.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : muldiv_seq_if slave modport (start/funct3/op_a/op_b/flush in,
//           stall/busy/done/result out)
module muldiv_seq (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  f3_r;
    logic [31:0] opnd_r;      // multiplicand magnitude or divisor magnitude
    logic [63:0] prod_r;      // product; low word doubles as dividend/quotient shifter
    logic [32:0] rem_r;       // partial remainder
    logic [4:0]  cnt_r;
    logic        neg_res_r;   // product / quotient must be negated
    logic        neg_rem_r;   // remainder must be negated (follows dividend)
    logic        byp_r;       // special-case division, skip the iterations
    logic [31:0] byp_val_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;

    logic        sign_a_s;
    logic        sign_b_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic        div0_s;
    logic        ovf_s;
    logic [31:0] byp_val_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [33:0] div_shift_s;
    logic [33:0] div_diff_s;
    logic [32:0] rem_next_s;
    logic        q_bit_s;
    logic [63:0] full_s;
    logic [31:0] quo_s;
    logic [31:0] rmd_s;
    logic [31:0] fix_val_s;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    // Decode operand signedness, magnitudes and the division special cases at acceptance.
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (bus.funct3)
            3'b001:         begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            3'b010:         begin sign_a_s = 1'b1; sign_b_s = 1'b0; end
            3'b100, 3'b110: begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
            default:        begin sign_a_s = 1'b0; sign_b_s = 1'b0; end
        endcase
        neg_a_s = sign_a_s & bus.op_a[31];
        neg_b_s = sign_b_s & bus.op_b[31];
        abs_a_s = cneg32(bus.op_a, neg_a_s);
        abs_b_s = cneg32(bus.op_b, neg_b_s);
        div0_s  = bus.funct3[2] & (bus.op_b == 32'd0);
        ovf_s   = bus.funct3[2] & ~bus.funct3[0] &
                  (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
        if (div0_s) begin
            byp_val_s = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            byp_val_s = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            byp_val_s = 32'h0000_0000;
        end
    end

    // One iteration step of both datapaths; the FSM picks the one matching funct3.
    always_comb begin
        if (prod_r[0]) begin
            mul_sum_s = {1'b0, prod_r[63:32]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, prod_r[63:32]};
        end
        mul_next_s  = {mul_sum_s, prod_r[31:1]};
        // Bring down the next dividend bit, then try to subtract the divisor.
        div_shift_s = {rem_r, prod_r[31]};
        div_diff_s  = div_shift_s - {2'b00, opnd_r};
        q_bit_s     = ~div_diff_s[33];
        if (q_bit_s) begin
            rem_next_s = div_diff_s[32:0];
        end else begin
            rem_next_s = div_shift_s[32:0];
        end
    end

    // Sign correction and output selection for the FIX cycle.
    always_comb begin
        full_s = cneg64(prod_r, neg_res_r);
        quo_s  = cneg32(prod_r[31:0], neg_res_r);
        rmd_s  = cneg32(rem_r[31:0], neg_rem_r);
        case (f3_r)
            3'b000:                 fix_val_s = full_s[31:0];
            3'b001, 3'b010, 3'b011: fix_val_s = full_s[63:32];
            3'b100, 3'b101:         fix_val_s = quo_s;
            3'b110, 3'b111:         fix_val_s = rmd_s;
            default:                fix_val_s = 32'h0000_0000;
        endcase
    end

    // Control FSM with registered busy/done/result and the iteration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            f3_r      <= 3'd0;
            opnd_r    <= 32'd0;
            prod_r    <= 64'd0;
            rem_r     <= 33'd0;
            cnt_r     <= 5'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            byp_r     <= 1'b0;
            byp_val_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
        end else if (bus.flush) begin
            // Abort: no done pulse and the previous result stays visible.
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        f3_r      <= bus.funct3;
                        cnt_r     <= 5'd0;
                        rem_r     <= 33'd0;
                        neg_res_r <= neg_a_s ^ neg_b_s;
                        neg_rem_r <= neg_a_s;
                        byp_r     <= div0_s | ovf_s;
                        byp_val_r <= byp_val_s;
                        if (bus.funct3[2]) begin
                            opnd_r <= abs_b_s;
                            prod_r <= {32'd0, abs_a_s};
                        end else begin
                            opnd_r <= abs_a_s;
                            prod_r <= {32'd0, abs_b_s};
                        end
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (byp_r) begin
                        result_r <= byp_val_r;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        if (f3_r[2]) begin
                            rem_r  <= rem_next_s;
                            prod_r <= {32'd0, prod_r[30:0], q_bit_s};
                        end else begin
                            prod_r <= mul_next_s;
                        end
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'd31) begin
                            state_r <= FIX;
                        end
                    end
                end
                FIX: begin
                    result_r <= fix_val_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    // A start seen here is deliberately not accepted.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // stall must react in the same cycle start appears, so it is decoded
    // from the state register; it stays low while reset is asserted.
    assign bus.stall  = ~reset & (((state_r == IDLE) & bus.start & ~bus.flush) |
                                  (state_r == CALC) | (state_r == FIX));
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0000_0000;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait (bounded) for done; report result, latency (edges
    // after the start edge, -1 on timeout), stall behaviour and pulse width.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output bit stall_ok, output bit pulse_ok);
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.flush  = 1'b0;
        bus.start  = 1'b1;
        #1;
        stall_ok = (bus.stall === 1'b1);
        tick();
        bus.start = 1'b0;
        lat = -1;
        res = 32'hx;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
        end
        res = bus.result;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        tick();
        pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.result !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got result=%h done=%b busy=%b required result=00000000 done=0 busy=0",
                     bus.result, bus.done, bus.busy);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b required 0", bus.stall);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got stall=%b busy=%b required 0 0", bus.stall, bus.busy);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [7] = '{3'd0, 3'd3, 3'd1, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] exs [7] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
        int          lts [7] = '{33, 33, 33, 1, 1, 1, 33};
        logic [31:0] res;
        int          lat;
        bit          s_ok, p_ok;
        for (int i = 0; i < 7; i++) begin
            do_op(f3s[i], as[i], bs[i], res, lat, s_ok, p_ok);
            checks++;
            if (res !== exs[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, exs[i]);
            end
            checks++;
            if (lat != lts[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, lts[i]);
            end
            checks++;
            if (!s_ok || !p_ok) begin
                errors++;
                $display("FAIL directed_stall_pulse[%0d]: got stall_ok=%0d pulse_ok=%0d required 1 1", i, s_ok, p_ok);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        bit          s_ok, p_ok, saw_done;
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, s_ok, p_ok);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL flush_setup: got %h required fffffffe", res);
        end
        bus.funct3 = 3'd4;
        bus.op_a   = 32'hFFFF_FFF9;
        bus.op_b   = 32'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || saw_done) begin
            errors++;
            $display("FAIL flush_abort: got busy=%b done=%b stall=%b early_done=%0d required 0 0 0 0",
                     bus.busy, bus.done, bus.stall, saw_done);
        end
        checks++;
        if (bus.result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL flush_result_held: got %h required fffffffe", bus.result);
        end
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat, s_ok, p_ok);
        checks++;
        if (res !== 32'hFFFF_FFFD || lat != 33) begin
            errors++;
            $display("FAIL flush_restart: got %h lat %0d required fffffffd lat 33", res, lat);
        end
        // flush beats start in the same cycle
        bus.funct3 = 3'd0;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority_stall: got %b required 0", bus.stall);
        end
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority_busy: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        logic [31:0] a0, b0, exp;
        int          lat;
        bit          saw_done;
        a0 = $urandom;
        b0 = $urandom;
        exp = ref_result(3'd1, a0, b0);
        bus.funct3 = 3'd1;
        bus.op_a   = a0;
        bus.op_b   = b0;
        bus.start  = 1'b1;
        tick();
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            bus.start  = 1'b1;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.op_a   = $urandom;
            bus.op_b   = $urandom;
            tick();
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (bus.result !== exp || lat != 33) begin
            errors++;
            $display("FAIL start_ignored: got %h lat %0d required %h lat 33", bus.result, lat, exp);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
        tick();
        // reset in the middle of an op
        bus.funct3 = 3'd5;
        bus.op_a   = $urandom;
        bus.op_b   = 32'd3;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.result !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got result=%h busy=%b done=%b required 00000000 0 0",
                     bus.result, bus.busy, bus.done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midop_reset_no_done: got done pulse required none");
        end
    endtask

    task automatic test_random_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int          lat, elat;
        bit          s_ok, p_ok;
        for (int i = 0; i < 40; i++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = pick();
            b    = pick();
            exp  = ref_result(f3, a, b);
            elat = ref_lat(f3, a, b);
            do_op(f3, a, b, res, lat, s_ok, p_ok);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL random_result[%0d] f3=%0d a=%h b=%h: got %h required %h", i, f3, a, b, res, exp);
            end
            checks++;
            if (lat != elat) begin
                errors++;
                $display("FAIL random_latency[%0d] f3=%0d: got %0d required %0d", i, f3, lat, elat);
            end
            checks++;
            if (!s_ok || !p_ok) begin
                errors++;
                $display("FAIL random_stall_pulse[%0d]: got stall_ok=%0d pulse_ok=%0d required 1 1", i, s_ok, p_ok);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        test_reset();
        test_directed();
        test_flush();
        test_start_ignored_and_reset();
        test_random_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
